switch_bounce_gen: RTL and testbench

Stimulus block that drives a mechanical-switch-like waveform from a clean level request. A requested level produces one edge, then a pseudo-random burst of glitch pulses, then a guaranteed stable settle period.
It feeds debounce_switch and similar input conditioners in self-test and loopback builds, standing in for the physical button.
Requests use a valid/ready handshake. Completion is reported with a one-cycle done pulse.

---
 rtl/switch_bounce_gen.sv | 198 +++++++++++++++++++
 tb/tb_switch_bounce_gen.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_bounce_gen.sv
// -----------------------------------------------------------------------------
// switch_bounce_gen
//
// Emulates a bouncing mechanical switch for self-test and loopback builds.
// A clean level request produces one edge on sw_out, then a pseudo-random
// burst of glitch pairs (each pair is one segment at the target level followed
// by one segment at the opposite level), then a stable settle period at the
// target level. A one-cycle done pulse marks the end of the settle period.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   a new target level is offered
//   req_level  in   target switch level
//   req_ready  out  idle, a request is accepted on this edge if req_valid
//   sw_out     out  emulated switch line (registered)
//   busy       out  a request is in progress (inverse of req_ready)
//   done       out  one-cycle pulse when the settle period completes
//
// Randomness comes from a 16-bit Galois LFSR (taps 16'hB400) that advances
// every cycle, idle or busy, so the waveform depends on the cycle of
// acceptance as well as on the seed.
// -----------------------------------------------------------------------------
module switch_bounce_gen #(
    parameter int          CLK_CYCLES       = 50_000_000,
    parameter int          SETTLE_CYCLES    = CLK_CYCLES / 50,
    parameter int          GLITCH_MIN       = 2,
    parameter int          GLITCH_SPAN_LOG2 = 2,
    parameter int          PAIRS_MAX        = 3,
    parameter logic [15:0] SEED             = 16'hACE1,
    parameter logic        INIT_LEVEL       = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_level,
    output logic req_ready,
    output logic sw_out,
    output logic busy,
    output logic done
);

    // Longest value the segment counter ever has to hold: either the settle
    // period or the longest possible glitch segment.
    localparam int GLITCH_LONGEST = GLITCH_MIN + (1 << GLITCH_SPAN_LOG2);
    localparam int CNT_MAX        = (SETTLE_CYCLES > GLITCH_LONGEST) ? SETTLE_CYCLES
                                                                     : GLITCH_LONGEST;
    localparam int CNT_W          = $clog2(CNT_MAX + 1);

    localparam logic [15:0]      LFSR_TAPS   = 16'hB400;
    localparam logic [3:0]       PAIRS_CAP   = 4'(PAIRS_MAX);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] GLITCH_BASE = CNT_W'(GLITCH_MIN);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GLITCH_ON,
        S_GLITCH_OFF,
        S_SETTLE
    } state_t;

    state_t           state_q,  state_d;
    logic             sw_q,     sw_d;
    logic             target_q, target_d;
    logic [3:0]       pairs_q,  pairs_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [15:0]      lfsr_q,   lfsr_d;
    logic             done_q,   done_d;

    logic             accept;
    logic [3:0]       lfsr_pairs;
    logic [CNT_W-1:0] seg_len;

    // -------------------------------------------------------------------------
    // Handshake and random draws
    // -------------------------------------------------------------------------
    assign req_ready = (state_q == S_IDLE);
    assign busy      = ~req_ready;
    assign accept    = req_valid && req_ready;

    // Glitch pair count is clipped, not wrapped, so large nibbles all map to
    // the maximum burst.
    assign lfsr_pairs = (lfsr_q[7:4] > PAIRS_CAP) ? PAIRS_CAP : lfsr_q[7:4];

    // Length of the segment being entered on this edge.
    assign seg_len = GLITCH_BASE + CNT_W'(lfsr_q[GLITCH_SPAN_LOG2-1:0]);

    // Right-shifting Galois LFSR; a non-zero seed never reaches zero.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LFSR_TAPS;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        sw_d     = sw_q;
        target_d = target_q;
        pairs_d  = pairs_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    target_d = req_level;
                    sw_d     = req_level;
                    // No level change means no edge and therefore no bounce.
                    if ((req_level != sw_q) && (lfsr_pairs != 4'd0)) begin
                        pairs_d = lfsr_pairs;
                        cnt_d   = seg_len;
                        state_d = S_GLITCH_ON;
                    end else begin
                        pairs_d = 4'd0;
                        cnt_d   = SETTLE_LOAD;
                        state_d = S_SETTLE;
                    end
                end
            end

            S_GLITCH_ON: begin
                if (cnt_q <= CNT_ONE) begin
                    sw_d    = ~target_q;
                    cnt_d   = seg_len;
                    state_d = S_GLITCH_OFF;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            S_GLITCH_OFF: begin
                if (cnt_q <= CNT_ONE) begin
                    sw_d    = target_q;
                    pairs_d = pairs_q - 4'd1;
                    if (pairs_q > 4'd1) begin
                        cnt_d   = seg_len;
                        state_d = S_GLITCH_ON;
                    end else begin
                        cnt_d   = SETTLE_LOAD;
                        state_d = S_SETTLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            S_SETTLE: begin
                if (cnt_q <= CNT_ONE) begin
                    // done and req_ready both become visible in the next cycle,
                    // so a request offered then is accepted back-to-back.
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                pairs_d = 4'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sw_q     <= INIT_LEVEL;
            target_q <= INIT_LEVEL;
            pairs_q  <= 4'd0;
            cnt_q    <= '0;
            lfsr_q   <= SEED;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sw_q     <= sw_d;
            target_q <= target_d;
            pairs_q  <= pairs_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            done_q   <= done_d;
        end
    end

    assign sw_out = sw_q;
    assign done   = done_q;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// -----------------------------------------------------------------------------
// tb_switch_bounce_gen
//
// Directed bench for switch_bounce_gen. Each accepted request expands into the
// expected per-cycle waveform (sw_out, done, req_ready) built segment by
// segment from a reference LFSR; those entries are queued and popped one per
// clock. Also contains a small debouncer model fed by sw_out for loopback.
// -----------------------------------------------------------------------------
module tb_switch_bounce_gen;

    localparam int          SETTLE = 20;
    localparam int          GMIN   = 2;
    localparam int          SPAN   = 2;
    localparam int          PMAX   = 3;
    localparam logic [15:0] SEED   = 16'hACE1;
    localparam int          DB_TO  = 10;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic req_valid = 1'b0;
    logic req_level = 1'b1;
    logic req_ready;
    logic sw_out;
    logic busy;
    logic done;

    switch_bounce_gen #(
        .SETTLE_CYCLES    (SETTLE),
        .GLITCH_MIN       (GMIN),
        .GLITCH_SPAN_LOG2 (SPAN),
        .PAIRS_MAX        (PMAX),
        .SEED             (SEED),
        .INIT_LEVEL       (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_level (req_level),
        .req_ready (req_ready),
        .sw_out    (sw_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic sw;
        logic done;
        logic ready;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        last_e;
    int          total = 0;
    int          bad   = 0;
    logic [15:0] lfsr_m;
    logic        model_sw;
    logic        prev_sw;
    int          edges_obs;
    int          edges_exp;
    int          acc_cnt;
    int          done_lat;
    int          rec_sel = 0;
    logic        rec_a[$];
    logic        rec_b[$];
    int          k_idle;

    // Debouncer model: output follows sw_out once it has differed for DB_TO
    // consecutive cycles.
    logic led1;
    int   db_cnt;
    int   led_toggles = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led1   <= 1'b1;
            db_cnt <= 0;
        end else if (sw_out != led1) begin
            if (db_cnt >= DB_TO - 1) begin
                led1        <= sw_out;
                db_cnt      <= 0;
                led_toggles <= led_toggles + 1;
            end else begin
                db_cnt <= db_cnt + 1;
            end
        end else begin
            db_cnt <= 0;
        end
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic [15:0] n;
        n = {1'b0, l[15:1]};
        if (l[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic logic [15:0] lfsr_step_n(input logic [15:0] l, input int n);
        logic [15:0] r;
        r = l;
        for (int i = 0; i < n; i++) r = lfsr_step(r);
        return r;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push_n(input logic sw, input int n);
        exp_t e;
        e.sw    = sw;
        e.done  = 1'b0;
        e.ready = 1'b0;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    // Expand a request accepted on the next edge into its expected waveform.
    task automatic push_req(input logic level);
        logic [15:0] l;
        int          p;
        int          nib;
        int          d;
        exp_t        e;
        l   = lfsr_m;
        nib = int'(l[7:4]);
        p   = (level == model_sw) ? 0 : ((nib > PMAX) ? PMAX : nib);
        edges_exp = (level == model_sw) ? 0 : 1 + 2 * p;
        for (int i = 0; i < p; i++) begin
            d = GMIN + int'(l[1:0]);
            push_n(level, d);
            l = lfsr_step_n(l, d);
            d = GMIN + int'(l[1:0]);
            push_n(~level, d);
            l = lfsr_step_n(l, d);
        end
        push_n(level, SETTLE);
        e.sw    = level;
        e.done  = 1'b1;
        e.ready = 1'b1;
        exp_q.push_back(e);
        model_sw  = level;
        prev_sw   = sw_out;
        edges_obs = 0;
        acc_cnt   = 0;
    endtask

    // Advance one clock, sample 1 time unit after the edge, compare.
    task automatic cyc();
        logic rst_seen;
        exp_t e;
        @(posedge clk);
        rst_seen = rst_n;
        #1;
        lfsr_m = rst_seen ? lfsr_step(lfsr_m) : SEED;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e.sw    = model_sw;
            e.done  = 1'b0;
            e.ready = 1'b1;
        end
        last_e = e;
        acc_cnt++;
        if (sw_out !== prev_sw) edges_obs++;
        prev_sw = sw_out;
        if (done === 1'b1) done_lat = acc_cnt;
        if (rec_sel == 1) rec_a.push_back(sw_out);
        if (rec_sel == 2) rec_b.push_back(sw_out);
        chk("sw_out", sw_out, e.sw);
        chk("done", done, e.done);
        chk("req_ready", req_ready, e.ready);
        chk("busy", busy, ~e.ready);
        if (e.done) chk_i("edge_count", edges_obs, edges_exp);
    endtask

    task automatic request(input logic level, input logic keep);
        req_valid = 1'b1;
        req_level = level;
        push_req(level);
        cyc();
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic run_to_done();
        int guard;
        guard = 0;
        while (!last_e.done && guard < 400) begin
            cyc();
            guard++;
        end
        chk("done_reached", done, 1'b1);
    endtask

    task automatic reset_seq();
        rst_n = 1'b0;
        exp_q.delete();
        model_sw = 1'b1;
        prev_sw  = 1'b1;
        lfsr_m   = SEED;
        repeat (3) cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        logic lvl;
        logic old;
        int   tog_before;
        int   guard;

        // Reset and idle after release.
        lfsr_m   = SEED;
        model_sw = 1'b1;
        prev_sw  = 1'b1;
        reset_seq();
        k_idle = 0;
        while ((k_idle < 2 || lfsr_m[7:4] == 4'd0) && k_idle < 64) begin
            cyc();
            k_idle++;
        end

        // Level change 1 -> 0 with glitch burst, recorded for replay.
        rec_sel = 1;
        request(1'b0, 1'b0);
        run_to_done();
        rec_sel = 0;
        chk_i("edges_odd", edges_obs % 2, 1);
        chk("edges_le7", (edges_obs <= 7), 1'b1);

        // Back to 1, then a same-level request.
        cyc();
        request(1'b1, 1'b0);
        run_to_done();
        cyc();
        cyc();
        request(1'b1, 1'b0);
        run_to_done();
        chk_i("same_level_latency", done_lat, 21);

        // Busy flood, then back-to-back accept in the done cycle.
        cyc();
        request(1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            req_level = ~req_level;
            cyc();
        end
        request(1'b1, 1'b0);
        run_to_done();

        // Mid-bounce reset during a glitch-off segment, then replay.
        reset_seq();
        repeat (k_idle) cyc();
        request(1'b0, 1'b0);
        guard = 0;
        while (!(last_e.sw == 1'b1 && last_e.ready == 1'b0) && guard < 100) begin
            cyc();
            guard++;
        end
        chk("reached_glitch_off", sw_out, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midreset_sw_out", sw_out, 1'b1);
        chk("midreset_req_ready", req_ready, 1'b1);
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_done", done, 1'b0);
        reset_seq();
        repeat (k_idle) cyc();
        rec_sel = 2;
        request(1'b0, 1'b0);
        run_to_done();
        rec_sel = 0;
        chk_i("replay_length", rec_b.size(), rec_a.size());
        for (int i = 0; i < rec_a.size() && i < rec_b.size(); i++) begin
            chk("replay_sample", rec_b[i], rec_a[i]);
        end

        // Loopback through the debouncer model, random requests.
        for (int n = 0; n < 50; n++) begin
            lvl        = 1'($urandom_range(0, 1));
            old        = model_sw;
            tog_before = led_toggles;
            request(lvl, 1'b0);
            run_to_done();
            chk("loop_led1", led1, lvl);
            chk_i("loop_led_toggles", led_toggles - tog_before, (lvl != old) ? 1 : 0);
            if ($urandom_range(0, 3) == 0) cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
